up_dwn_cnt_prm: RTL



---
 rtl/up_dwn_cnt_prm.sv | 99 +++++++++
 1 files changed

// File: rtl/up_dwn_cnt_prm.sv
// Parametrised up/down counter with wrap/saturate modes, prescaled enable, clear and load.
// Latency: one cycle from a sampled tick/load/clear to cnt, ovf and unf. No backpressure: it is a free-running primitive.
module up_dwn_cnt_prm #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16,
    parameter bit SAT   = 1'b0,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dwn,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);

    // One extra bit keeps MOD-1 and the clamp compare exact when MOD == 2^WIDTH.
    localparam int            W1  = WIDTH + 1;
    localparam logic [W1-1:0] TOP = W1'(MOD - 1);

    logic             tick;
    logic [W1-1:0]    cnt_x;
    logic [W1-1:0]    ld_x;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    assign cnt_x  = {1'b0, cnt};
    assign ld_x   = {1'b0, ld_val};
    assign at_max = (cnt_x == TOP);
    assign at_min = (cnt_x == '0);

    generate
        if (DIV > 1) begin : g_pre
            localparam int PW = $clog2(DIV);
            logic [PW-1:0] pre;

            assign tick = en && (pre == PW'(DIV - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pre <= '0;
                end else if (clr || ld) begin
                    pre <= '0;
                end else if (en) begin
                    pre <= tick ? '0 : pre + PW'(1);
                end
            end
        end else begin : g_no_pre
            assign tick = en;
        end
    endgenerate

    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
        end else if (ld) begin
            cnt_nxt = (ld_x <= TOP) ? ld_val : WIDTH'(TOP);
        end else if (tick) begin
            if (!dwn) begin
                if (cnt_x < TOP) begin
                    cnt_nxt = WIDTH'(cnt_x + W1'(1));
                end else begin
                    ovf_nxt = 1'b1;
                    cnt_nxt = SAT ? cnt : '0;
                end
            end else begin
                if (cnt_x != '0) begin
                    cnt_nxt = WIDTH'(cnt_x - W1'(1));
                end else begin
                    unf_nxt = 1'b1;
                    cnt_nxt = SAT ? cnt : WIDTH'(TOP);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
        end
    end

endmodule
